// File: rtl/instr_fetch_if.sv
// Fetch-unit signal bundle: control-unit instruction handshake, branch redirect
// and the single-outstanding memory read port.
interface instr_fetch_if;
  logic        ir_load;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] ir_pc;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  ir_load, branch_valid, branch_target, mem_ack, mem_rdata,
    output ir, ir_valid, ir_pc, mem_req, mem_addr
  );

  modport slave (
    output ir_load, branch_valid, branch_target, mem_ack, mem_rdata,
    input  ir, ir_valid, ir_pc, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: 2-deep prefetch FIFO of {pc, instr} fed by one
// outstanding memory read, with branch redirect and a held instruction register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic         mclk,
  input logic         nreset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] drain_addr;
  logic        pending;
  logic        push, pop, flush;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  always_comb begin
    state_nxt    = state;
    push         = 1'b0;
    flush        = bus.branch_valid;
    pop          = (pending || bus.ir_load) && (count != 2'd0) && !bus.branch_valid;
    fetch_pc_nxt = fetch_pc;
    count_nxt    = count;

    case (state)
      S_IDLE: begin
        if (!bus.branch_valid && (count != 2'd2))
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.branch_valid)
          state_nxt = bus.mem_ack ? S_IDLE : S_DRAIN;
        else if (bus.mem_ack)
          push = 1'b1;
      end
      S_DRAIN: begin
        if (bus.mem_ack)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    count_nxt = count + {1'b0, push} - {1'b0, pop};
    if (flush) begin
      count_nxt    = 2'd0;
      fetch_pc_nxt = align_word(bus.branch_target);
    end else if (push) begin
      fetch_pc_nxt = fetch_pc + 32'd4;
    end

    // Keep the request going only while the FIFO still has room after this cycle.
    if (push)
      state_nxt = (count_nxt == 2'd2) ? S_IDLE : S_WAIT;
  end

  assign bus.mem_req  = (state != S_IDLE);
  assign bus.mem_addr = (state == S_DRAIN) ? drain_addr : fetch_pc;

  always_ff @(posedge mclk) begin
    if (nreset) begin
      state        <= S_IDLE;
      fetch_pc     <= RESET_VECTOR;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      pending      <= 1'b0;
      bus.ir_valid <= 1'b0;
      bus.ir       <= 32'd0;
      bus.ir_pc    <= 32'd0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      count        <= count_nxt;
      bus.ir_valid <= pop;

      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end

      // A branch leaves pending set so the redirected stream serves it.
      if (pop)
        pending <= 1'b0;
      else if (bus.ir_load)
        pending <= 1'b1;

      if (pop) begin
        bus.ir    <= fifo_instr[rd_ptr];
        bus.ir_pc <= fifo_pc[rd_ptr];
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= bus.mem_rdata;
    end
    if (state == S_WAIT && state_nxt == S_DRAIN)
      drain_addr <= fetch_pc;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder with programmable ack delay,
// expected-instruction queue checked on every ir_valid pulse.
module tb_instr_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic mclk = 1'b0;
  logic nreset = 1'b1;
  always #5 mclk = ~mclk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .mclk(mclk), .nreset(nreset), .bus(bus)
  );
  instr_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
    .mclk(mclk), .nreset(nreset), .bus(bus2)
  );

  assign bus2.mem_ack       = 1'b1;
  assign bus2.mem_rdata     = bus2.mem_addr ^ KEY;
  assign bus2.branch_valid  = 1'b0;
  assign bus2.branch_target = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic [31:0] acked[$];
  logic [31:0] q2[$];
  int          ack_delay;
  bit          force_ack;
  int          last_ack_cyc;
  int          last_wait;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic issue_load();
    bus.ir_load = 1'b1;
    sb.push_back({exp_pc, exp_pc ^ KEY});
    exp_pc = exp_pc + 32'd4;
    tick();
    bus.ir_load = 1'b0;
  endtask

  task automatic do_branch(input logic [31:0] target);
    bus.branch_valid  = 1'b1;
    bus.branch_target = target;
    exp_pc = {target[31:2], 2'b00};
    foreach (sb[i]) begin
      sb[i]  = {exp_pc, exp_pc ^ KEY};
      exp_pc = exp_pc + 32'd4;
    end
    tick();
    bus.branch_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int vcyc);
    int n;
    n    = 0;
    vcyc = -1;
    while (n < limit) begin
      tick();
      n++;
      if (bus.ir_valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
    if (vcyc < 0) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Memory responder: acks after ack_delay idle request cycles.
  initial begin
    int          wait_cnt;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    wait_cnt  = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'd0;
    forever begin
      @(posedge mclk);
      #2;
      if (prev_req && !prev_ack && bus.mem_req)
        check_val("mem_addr_hold", bus.mem_addr, prev_addr);
      if (force_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end else if (bus.mem_req && wait_cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ KEY;
        acked.push_back(bus.mem_addr);
        last_ack_cyc = cyc;
        last_wait    = wait_cnt;
        wait_cnt     = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt    = bus.mem_req ? wait_cnt + 1 : 0;
      end
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
    end
  end

  always @(negedge mclk) begin
    if (bus.ir_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("sb_ir_pc", bus.ir_pc, e.pc);
        check_val("sb_ir", bus.ir, e.instr);
      end
    end
    if (!nreset && bus2.mem_req === 1'b1)
      q2.push_back(bus2.mem_addr);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    bus.ir_load       = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'd0;
    bus2.ir_load      = 1'b0;
    exp_pc    = 32'd0;
    ack_delay = 0;
    force_ack = 1'b0;

    nreset = 1'b1;
    tick();
    tick();
    check_val("rst_ir", bus.ir, 32'd0);
    check_val("rst_ir_pc", bus.ir_pc, 32'd0);
    check_val("rst_ir_valid", bus.ir_valid, 32'd0);
    check_val("rst_mem_req", bus.mem_req, 32'd0);
    check_val("rst_mem_addr", bus.mem_addr, 32'd0);
    check_val("rst_wrap_addr", bus2.mem_addr, 32'hFFFF_FFF8);

    // Reset release with acks every cycle
    nreset = 1'b0;
    check_val("c0_req", bus.mem_req, 32'd0);
    tick();
    check_val("c1_req", bus.mem_req, 32'd1);
    check_val("c1_addr", bus.mem_addr, 32'h0);
    check_val("c1_wrap_addr", bus2.mem_addr, 32'hFFFF_FFF8);
    tick();
    check_val("c2_addr", bus.mem_addr, 32'h4);
    check_val("c2_wrap_addr", bus2.mem_addr, 32'hFFFF_FFFC);
    tick();
    check_val("c3_req", bus.mem_req, 32'd0);
    check_val("c3_addr", bus.mem_addr, 32'h8);
    check_val("c3_wrap_req", bus2.mem_req, 32'd0);
    tick();
    tick();
    check_val("fill_acks", acked.size(), 32'd2);

    // Pop from a full FIFO: one-cycle latency
    bus2.ir_load = 1'b1;
    issue_load();
    bus2.ir_load = 1'b0;
    check_val("pop_valid", bus.ir_valid, 32'd1);
    check_val("pop_ir", bus.ir, 32'hA5A5_A5A5);
    check_val("pop_ir_pc", bus.ir_pc, 32'h0);
    check_val("wrap_valid", bus2.ir_valid, 32'd1);
    check_val("wrap_ir_pc", bus2.ir_pc, 32'hFFFF_FFF8);
    check_val("wrap_ir", bus2.ir, 32'hFFFF_FFF8 ^ KEY);
    tick();
    check_val("pulse_end", bus.ir_valid, 32'd0);
    repeat (4) tick();
    check_val("refill_acks", acked.size(), 32'd3);
    if (acked.size() >= 3) check_val("refill_addr", acked[2], 32'h8);
    check_val("wrap_n", q2.size(), 32'd3);
    for (int i = 0; i < 3 && i < q2.size(); i++) begin
      logic [31:0] wexp;
      wexp = 32'hFFFF_FFF8 + 32'(i * 4);
      check_val("wrap_seq", q2[i], wexp);
    end

    // Slow memory: drain FIFO then load from empty
    ack_delay = 3;
    issue_load();
    check_val("v4_valid", bus.ir_valid, 32'd1);
    issue_load();
    check_val("v8_valid", bus.ir_valid, 32'd1);
    issue_load();
    wait_valid("lat2", 20, vc);
    check_val("ack_to_valid", 32'(vc - last_ack_cyc), 32'd2);
    check_val("ack_wait", 32'(last_wait), 32'd3);
    check_val("slow_addr", acked[acked.size()-1], 32'hC);

    // Branch while a request is outstanding, with a load pending
    ack_delay = 50;
    issue_load();
    do_branch(32'h0000_1003);
    check_val("drain_req", bus.mem_req, 32'd1);
    check_val("drain_addr", bus.mem_addr, 32'h10);
    check_val("hold_ir_pc", bus.ir_pc, 32'hC);
    check_val("drain_no_valid", bus.ir_valid, 32'd0);
    ack_delay = 1;
    wait_valid("branch_load", 30, vc);
    check_val("tgt_addr", acked[acked.size()-1], 32'h1000);
    check_val("drained_addr", acked[acked.size()-2], 32'h10);

    // Reset in S_WAIT with one FIFO entry, acks during and after reset
    tick();
    check_val("pre_rst_ack", acked[acked.size()-1], 32'h1004);
    ack_delay = 50;
    force_ack = 1'b1;
    nreset    = 1'b1;
    sb.delete();
    exp_pc = 32'd0;
    tick();
    check_val("mid_rst_req", bus.mem_req, 32'd0);
    check_val("mid_rst_valid", bus.ir_valid, 32'd0);
    check_val("mid_rst_ir", bus.ir, 32'd0);
    check_val("mid_rst_addr", bus.mem_addr, 32'd0);
    nreset = 1'b0;
    tick();
    force_ack = 1'b0;
    ack_delay = 0;
    check_val("post_rst_req", bus.mem_req, 32'd1);
    check_val("post_rst_addr", bus.mem_addr, 32'd0);
    issue_load();
    wait_valid("post_rst_load", 10, vc);

    repeat (3) tick();
    check_val("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
